cp0_ctrl: RTL and testbench

- Coprocessor-0 register bank and exception-commit sequencer for the MIPS pipeline, located at the MEM stage beside the exception-decode logic.
- Holds Status, Cause, EPC, BadVAddr, Count and Compare.
- Applies mtc0 writes and updates the registers when a decoded exception or eret commits.
- Samples interrupt lines into Cause.IP, runs the Count/Compare timer, and feeds status/cause/epc back to exception decode.

---
 rtl/cp0_ctrl_pkg.sv | 59 +++++
 rtl/cp0_ctrl_timer.sv | 69 ++++++
 rtl/cp0_ctrl.sv | 151 +++++++++++++++
 tb/tb_cp0_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_ctrl_pkg.sv
// Shared CP0 constants: register numbers, Status/Cause field positions, ExcCodes and
// the exception-type encoding produced by exception decode.
package cp0_ctrl_pkg;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    localparam int STATUS_IE      = 0;
    localparam int STATUS_EXL     = 1;
    localparam int STATUS_IM_LO   = 8;
    localparam int STATUS_IM_HI   = 15;
    localparam int CAUSE_EXC_LO   = 2;
    localparam int CAUSE_EXC_HI   = 6;
    localparam int CAUSE_IPSW_LO  = 8;
    localparam int CAUSE_IPSW_HI  = 9;
    localparam int CAUSE_IP_LO    = 10;
    localparam int CAUSE_IP_HI    = 15;
    localparam int CAUSE_TI       = 30;
    localparam int CAUSE_BD       = 31;

    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

    localparam logic [4:0] EXCCODE_INT  = 5'h00;
    localparam logic [4:0] EXCCODE_ADEL = 5'h04;
    localparam logic [4:0] EXCCODE_ADES = 5'h05;
    localparam logic [4:0] EXCCODE_SYS  = 5'h08;
    localparam logic [4:0] EXCCODE_BP   = 5'h09;
    localparam logic [4:0] EXCCODE_RI   = 5'h0a;
    localparam logic [4:0] EXCCODE_OV   = 5'h0c;

    localparam logic [31:0] EXC_TYPE_NOEXC = 32'h0000_0000;
    localparam logic [31:0] EXC_TYPE_INT   = 32'h0000_0001;
    localparam logic [31:0] EXC_TYPE_ADEL  = 32'h0000_0004;
    localparam logic [31:0] EXC_TYPE_ADES  = 32'h0000_0005;
    localparam logic [31:0] EXC_TYPE_SYS   = 32'h0000_0008;
    localparam logic [31:0] EXC_TYPE_BP    = 32'h0000_0009;
    localparam logic [31:0] EXC_TYPE_RI    = 32'h0000_000a;
    localparam logic [31:0] EXC_TYPE_OV    = 32'h0000_000c;
    localparam logic [31:0] EXC_TYPE_ERET  = 32'h0000_000e;

    function automatic logic [4:0] exccode_of(input logic [31:0] exc_type);
        logic [4:0] code;
        case (exc_type)
            EXC_TYPE_ADEL: code = EXCCODE_ADEL;
            EXC_TYPE_ADES: code = EXCCODE_ADES;
            EXC_TYPE_SYS:  code = EXCCODE_SYS;
            EXC_TYPE_BP:   code = EXCCODE_BP;
            EXC_TYPE_RI:   code = EXCCODE_RI;
            EXC_TYPE_OV:   code = EXCCODE_OV;
            default:       code = EXCCODE_INT;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/cp0_ctrl_timer.sv
// Count/Compare timer: Count advances every COUNT_DIV clocks; TI latches when the next
// Count equals a non-zero Compare and is cleared only by a Compare write.
module cp0_timer
    import cp0_ctrl_pkg::*;
#(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        timer_int
);

    logic [31:0] count_reg;
    logic [31:0] count_next;
    logic [31:0] compare_reg;
    logic        ti_reg;
    logic        tick;

    generate
        if (COUNT_DIV == 1) begin : g_div1
            assign tick = 1'b1;
        end else begin : g_div2
            logic phase_reg;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    phase_reg <= 1'b0;
                end else begin
                    phase_reg <= ~phase_reg;
                end
            end
            assign tick = phase_reg;
        end
    endgenerate

    always_comb begin
        count_next = count_reg;
        if (count_we) begin
            count_next = wdata;
        end else if (tick) begin
            count_next = count_reg + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg   <= 32'd0;
            compare_reg <= 32'd0;
            ti_reg      <= 1'b0;
        end else begin
            count_reg <= count_next;
            if (compare_we) begin
                compare_reg <= wdata;
                ti_reg      <= 1'b0;
            end else if (compare_reg != 32'd0 && count_next == compare_reg) begin
                ti_reg <= 1'b1;
            end
        end
    end

    assign count     = count_reg;
    assign compare   = compare_reg;
    assign timer_int = ti_reg;

endmodule

// File: rtl/cp0_ctrl.sv
// CP0 register bank and exception/eret commit sequencer at the MEM stage.
// Optional Count/Compare timer is built only when CP0_TIMER_EN is defined.
module cp0_ctrl
    import cp0_ctrl_pkg::*;
#(
    parameter int          COUNT_DIV  = 2,
    parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [4:0]  raddr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    input  logic [31:0] except_type_i,
    input  logic [31:0] pc_i,
    input  logic        in_delayslot_i,
    input  logic [31:0] badvaddr_i,
    input  logic [5:0]  int_i,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] badvaddr_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        timer_int_o
);

    logic [31:0] status_reg, status_next;
    logic [31:0] epc_reg, epc_next;
    logic [31:0] badvaddr_reg, badvaddr_next;
    logic        cause_bd_reg, cause_bd_next;
    logic [1:0]  cause_sw_reg, cause_sw_next;
    logic [4:0]  cause_exc_reg, cause_exc_next;
    logic [5:0]  cause_ip_reg;
    logic [31:0] count;
    logic [31:0] compare;
    logic        ti;
    logic        exc_commit;
    logic        eret_commit;

    if (COUNT_DIV != 1 && COUNT_DIV != 2) begin : g_bad_count_div
        $error("cp0_ctrl: COUNT_DIV must be 1 or 2");
    end

`ifdef CP0_TIMER_EN
    cp0_timer #(
        .COUNT_DIV (COUNT_DIV)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .count_we   (we_i && waddr_i == CP0_COUNT),
        .compare_we (we_i && waddr_i == CP0_COMPARE),
        .wdata      (wdata_i),
        .count      (count),
        .compare    (compare),
        .timer_int  (ti)
    );
`else
    assign count   = 32'd0;
    assign compare = 32'd0;
    assign ti      = 1'b0;
`endif

    // mtc0 values are computed first so that commit updates override only the fields they own.
    always_comb begin
        exc_commit  = (except_type_i != EXC_TYPE_NOEXC) && (except_type_i != EXC_TYPE_ERET);
        eret_commit = (except_type_i == EXC_TYPE_ERET);

        status_next    = status_reg;
        epc_next       = epc_reg;
        badvaddr_next  = badvaddr_reg;
        cause_bd_next  = cause_bd_reg;
        cause_sw_next  = cause_sw_reg;
        cause_exc_next = cause_exc_reg;

        if (we_i) begin
            case (waddr_i)
                CP0_STATUS: status_next   = (status_reg & ~STATUS_WMASK) | (wdata_i & STATUS_WMASK);
                CP0_CAUSE:  cause_sw_next = wdata_i[CAUSE_IPSW_HI:CAUSE_IPSW_LO];
                CP0_EPC:    epc_next      = wdata_i;
                default:    ;
            endcase
        end

        if (exc_commit) begin
            // A nested exception keeps the original return point and BD flag.
            if (!status_reg[STATUS_EXL]) begin
                epc_next      = in_delayslot_i ? pc_i - 32'd4 : pc_i;
                cause_bd_next = in_delayslot_i;
            end
            status_next[STATUS_EXL] = 1'b1;
            cause_exc_next          = exccode_of(except_type_i);
            if (except_type_i == EXC_TYPE_ADEL || except_type_i == EXC_TYPE_ADES) begin
                badvaddr_next = badvaddr_i;
            end
        end else if (eret_commit) begin
            status_next[STATUS_EXL] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            status_reg    <= STATUS_RST;
            epc_reg       <= 32'd0;
            badvaddr_reg  <= 32'd0;
            cause_bd_reg  <= 1'b0;
            cause_sw_reg  <= 2'b00;
            cause_exc_reg <= 5'd0;
            cause_ip_reg  <= 6'd0;
        end else begin
            status_reg    <= status_next;
            epc_reg       <= epc_next;
            badvaddr_reg  <= badvaddr_next;
            cause_bd_reg  <= cause_bd_next;
            cause_sw_reg  <= cause_sw_next;
            cause_exc_reg <= cause_exc_next;
            cause_ip_reg  <= {int_i[5] | ti, int_i[4:0]};
        end
    end

    always_comb begin
        cause_o                            = 32'd0;
        cause_o[CAUSE_BD]                  = cause_bd_reg;
        cause_o[CAUSE_TI]                  = ti;
        cause_o[CAUSE_IP_HI:CAUSE_IP_LO]   = cause_ip_reg;
        cause_o[CAUSE_IPSW_HI:CAUSE_IPSW_LO] = cause_sw_reg;
        cause_o[CAUSE_EXC_HI:CAUSE_EXC_LO] = cause_exc_reg;
    end

    assign status_o    = status_reg;
    assign epc_o       = epc_reg;
    assign badvaddr_o  = badvaddr_reg;
    assign count_o     = count;
    assign compare_o   = compare;
    assign timer_int_o = ti;

    always_comb begin
        case (raddr_i)
            CP0_BADVADDR: rdata_o = badvaddr_reg;
            CP0_COUNT:    rdata_o = count;
            CP0_COMPARE:  rdata_o = compare;
            CP0_STATUS:   rdata_o = status_reg;
            CP0_CAUSE:    rdata_o = cause_o;
            CP0_EPC:      rdata_o = epc_reg;
            default:      rdata_o = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_cp0_ctrl.sv
// Directed bench for cp0_ctrl: vector table for mtc0/exception/eret behaviour plus
// hand-written sequences for timer and asynchronous reset.
module tb_cp0_ctrl;
    import cp0_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        we_i;
    logic [4:0]  waddr_i, raddr_i;
    logic [31:0] wdata_i, rdata_o, except_type_i, pc_i, badvaddr_i;
    logic        in_delayslot_i;
    logic [5:0]  int_i;
    logic [31:0] status_o, cause_o, epc_o, badvaddr_o, count_o, compare_o;
    logic        timer_int_o;

    always #5 clk = ~clk;

    cp0_ctrl #(
        .COUNT_DIV  (2),
        .STATUS_RST (32'h0040_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .we_i           (we_i),
        .waddr_i        (waddr_i),
        .raddr_i        (raddr_i),
        .wdata_i        (wdata_i),
        .rdata_o        (rdata_o),
        .except_type_i  (except_type_i),
        .pc_i           (pc_i),
        .in_delayslot_i (in_delayslot_i),
        .badvaddr_i     (badvaddr_i),
        .int_i          (int_i),
        .status_o       (status_o),
        .cause_o        (cause_o),
        .epc_o          (epc_o),
        .badvaddr_o     (badvaddr_o),
        .count_o        (count_o),
        .compare_o      (compare_o),
        .timer_int_o    (timer_int_o)
    );

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [31:0] exc;
        logic [31:0] pc;
        logic        ds;
        logic [31:0] bv;
        logic [5:0]  intr;
        logic [4:0]  raddr;
        logic [31:0] exp_status;
        logic [31:0] exp_cause;
        logic [31:0] exp_epc;
        logic [31:0] exp_bv;
        logic [31:0] exp_rdata;
    } vec_t;

    int checks = 0;
    int errors = 0;
    vec_t vecs[17];

    function automatic vec_t mk(input logic we, input logic [4:0] waddr, input logic [31:0] wdata,
                                input logic [31:0] exc, input logic [31:0] pc, input logic ds,
                                input logic [31:0] bv, input logic [5:0] intr, input logic [4:0] raddr,
                                input logic [31:0] st, input logic [31:0] ca, input logic [31:0] ep,
                                input logic [31:0] bva, input logic [31:0] rd);
        vec_t v;
        v.we = we; v.waddr = waddr; v.wdata = wdata; v.exc = exc; v.pc = pc; v.ds = ds;
        v.bv = bv; v.intr = intr; v.raddr = raddr;
        v.exp_status = st; v.exp_cause = ca; v.exp_epc = ep; v.exp_bv = bva; v.exp_rdata = rd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] waddr, input logic [31:0] wdata,
                         input logic [31:0] exc, input logic [31:0] pc, input logic ds,
                         input logic [31:0] bv, input logic [5:0] intr, input logic [4:0] raddr);
        @(negedge clk);
        we_i = we; waddr_i = waddr; wdata_i = wdata; except_type_i = exc; pc_i = pc;
        in_delayslot_i = ds; badvaddr_i = bv; int_i = intr; raddr_i = raddr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [4:0] raddr);
        drive(1'b0, 5'd0, 32'd0, EXC_TYPE_NOEXC, 32'd0, 1'b0, 32'd0, 6'd0, raddr);
    endtask

    task automatic mtc0(input logic [4:0] waddr, input logic [31:0] wdata);
        drive(1'b1, waddr, wdata, EXC_TYPE_NOEXC, 32'd0, 1'b0, 32'd0, 6'd0, waddr);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_status"},   status_o,    32'h0040_0000);
        chk({tag, "_cause"},    cause_o,     32'd0);
        chk({tag, "_epc"},      epc_o,       32'd0);
        chk({tag, "_badvaddr"}, badvaddr_o,  32'd0);
        chk({tag, "_count"},    count_o,     32'd0);
        chk({tag, "_compare"},  compare_o,   32'd0);
        chk({tag, "_ti"},       {31'd0, timer_int_o}, 32'd0);
    endtask

    initial begin
        int found;

        vecs[0]  = mk(1, CP0_STATUS, 32'hFFFF_FFFF, EXC_TYPE_NOEXC, 0, 0, 0, 6'b000000, CP0_STATUS,
                      32'h0040_FF03, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0040_FF03);
        vecs[1]  = mk(1, CP0_CAUSE, 32'hFFFF_FFFF, EXC_TYPE_NOEXC, 0, 0, 0, 6'b000000, CP0_CAUSE,
                      32'h0040_FF03, 32'h0000_0300, 32'h0000_0000, 32'h0000_0000, 32'h0000_0300);
        vecs[2]  = mk(1, CP0_STATUS, 32'h0000_FF01, EXC_TYPE_NOEXC, 0, 0, 0, 6'b000000, CP0_STATUS,
                      32'h0040_FF01, 32'h0000_0300, 32'h0000_0000, 32'h0000_0000, 32'h0040_FF01);
        vecs[3]  = mk(0, 0, 0, EXC_TYPE_ADEL, 32'hBFC0_0104, 1, 32'h8000_0003, 6'b000000, CP0_EPC,
                      32'h0040_FF03, 32'h8000_0310, 32'hBFC0_0100, 32'h8000_0003, 32'hBFC0_0100);
        vecs[4]  = mk(0, 0, 0, EXC_TYPE_SYS, 32'hBFC0_0200, 0, 32'h0, 6'b000000, CP0_CAUSE,
                      32'h0040_FF03, 32'h8000_0320, 32'hBFC0_0100, 32'h8000_0003, 32'h8000_0320);
        vecs[5]  = mk(0, 0, 0, EXC_TYPE_ERET, 0, 0, 0, 6'b000000, CP0_STATUS,
                      32'h0040_FF01, 32'h8000_0320, 32'hBFC0_0100, 32'h8000_0003, 32'h0040_FF01);
        vecs[6]  = mk(0, 0, 0, EXC_TYPE_NOEXC, 0, 0, 0, 6'b101010, CP0_BADVADDR,
                      32'h0040_FF01, 32'h8000_AB20, 32'hBFC0_0100, 32'h8000_0003, 32'h8000_0003);
        vecs[7]  = mk(1, CP0_EPC, 32'h1111_1111, EXC_TYPE_OV, 32'h0000_2000, 0, 0, 6'b000000, CP0_EPC,
                      32'h0040_FF03, 32'h0000_0330, 32'h0000_2000, 32'h8000_0003, 32'h0000_2000);
        vecs[8]  = mk(1, CP0_STATUS, 32'h0000_0000, EXC_TYPE_ERET, 0, 0, 0, 6'b000000, CP0_STATUS,
                      32'h0040_0000, 32'h0000_0330, 32'h0000_2000, 32'h8000_0003, 32'h0040_0000);
        vecs[9]  = mk(1, CP0_STATUS, 32'h0000_FF01, EXC_TYPE_NOEXC, 0, 0, 0, 6'b000000, CP0_STATUS,
                      32'h0040_FF01, 32'h0000_0330, 32'h0000_2000, 32'h8000_0003, 32'h0040_FF01);
        vecs[10] = mk(1, CP0_CAUSE, 32'h0000_0000, EXC_TYPE_BP, 32'h0000_3000, 1, 0, 6'b000000, CP0_CAUSE,
                      32'h0040_FF03, 32'h8000_0024, 32'h0000_2FFC, 32'h8000_0003, 32'h8000_0024);
        vecs[11] = mk(1, CP0_BADVADDR, 32'h1234_5678, EXC_TYPE_NOEXC, 0, 0, 0, 6'b000001, CP0_BADVADDR,
                      32'h0040_FF03, 32'h8000_0424, 32'h0000_2FFC, 32'h8000_0003, 32'h8000_0003);
        vecs[12] = mk(1, 5'd5, 32'hFFFF_FFFF, EXC_TYPE_NOEXC, 0, 0, 0, 6'b000000, 5'd5,
                      32'h0040_FF03, 32'h8000_0024, 32'h0000_2FFC, 32'h8000_0003, 32'h0000_0000);
        vecs[13] = mk(0, 0, 0, EXC_TYPE_ADES, 32'h0000_4000, 0, 32'h0000_BEEF, 6'b000000, CP0_BADVADDR,
                      32'h0040_FF03, 32'h8000_0014, 32'h0000_2FFC, 32'h0000_BEEF, 32'h0000_BEEF);
        vecs[14] = mk(0, 0, 0, EXC_TYPE_INT, 32'h0000_5000, 0, 32'h1, 6'b100000, CP0_EPC,
                      32'h0040_FF03, 32'h8000_8000, 32'h0000_2FFC, 32'h0000_BEEF, 32'h0000_2FFC);
        vecs[15] = mk(1, CP0_CAUSE, 32'h0000_0300, EXC_TYPE_ERET, 0, 0, 0, 6'b000000, CP0_CAUSE,
                      32'h0040_FF01, 32'h8000_0300, 32'h0000_2FFC, 32'h0000_BEEF, 32'h8000_0300);
        vecs[16] = mk(0, 0, 0, EXC_TYPE_RI, 32'h0000_6000, 0, 0, 6'b000000, CP0_EPC,
                      32'h0040_FF03, 32'h0000_0328, 32'h0000_6000, 32'h0000_BEEF, 32'h0000_6000);

        rst = 1'b0;
        we_i = 1'b0; waddr_i = 5'd0; raddr_i = 5'd0; wdata_i = 32'd0;
        except_type_i = EXC_TYPE_NOEXC; pc_i = 32'd0; in_delayslot_i = 1'b0;
        badvaddr_i = 32'd0; int_i = 6'd0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset");
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].we, vecs[i].waddr, vecs[i].wdata, vecs[i].exc, vecs[i].pc,
                  vecs[i].ds, vecs[i].bv, vecs[i].intr, vecs[i].raddr);
            chk($sformatf("v%0d_status", i),   status_o,   vecs[i].exp_status);
            chk($sformatf("v%0d_cause", i),    cause_o,    vecs[i].exp_cause);
            chk($sformatf("v%0d_epc", i),      epc_o,      vecs[i].exp_epc);
            chk($sformatf("v%0d_badvaddr", i), badvaddr_o, vecs[i].exp_bv);
            chk($sformatf("v%0d_rdata", i),    rdata_o,    vecs[i].exp_rdata);
            $display("vec %0d: status=%08h cause=%08h epc=%08h badvaddr=%08h rdata=%08h",
                     i, status_o, cause_o, epc_o, badvaddr_o, rdata_o);
        end

`ifdef CP0_TIMER_EN
        mtc0(CP0_COMPARE, 32'd10);
        chk("tmr_compare_wr", compare_o, 32'd10);
        mtc0(CP0_COUNT, 32'd0);
        chk("tmr_count_wr", count_o, 32'd0);
        found = 0;
        for (int n = 1; n <= 40; n++) begin
            idle(CP0_COUNT);
            if (timer_int_o) begin
                found = n;
                break;
            end
        end
        chk("tmr_ti_latency_ok", {31'd0, (found >= 18 && found <= 21)}, 32'd1);
        chk("tmr_count_at_ti", count_o, 32'd10);
        idle(CP0_CAUSE);
        chk("tmr_cause_ip7", {31'd0, cause_o[15]}, 32'd1);
        chk("tmr_cause_ti", {31'd0, cause_o[30]}, 32'd1);
        mtc0(CP0_COMPARE, 32'd100);
        chk("tmr_ti_clear", {31'd0, timer_int_o}, 32'd0);
        chk("tmr_cause_ti_clear", {31'd0, cause_o[30]}, 32'd0);
        idle(CP0_CAUSE);
        chk("tmr_cause_ip7_clear", {31'd0, cause_o[15]}, 32'd0);
        mtc0(CP0_COUNT, 32'hFFFF_FFFF);
        chk("tmr_count_max", count_o, 32'hFFFF_FFFF);
        found = 0;
        for (int n = 1; n <= 4; n++) begin
            idle(CP0_COUNT);
            if (count_o == 32'd0) begin
                found = n;
                break;
            end
        end
        chk("tmr_wrap_seen", {31'd0, (found != 0)}, 32'd1);
        chk("tmr_wrap_rdata", rdata_o, 32'd0);
        $display("timer: wrap after %0d cycles, count=%08h", found, count_o);
        mtc0(CP0_COUNT, 32'h0000_1234);
        chk("pre_reset_count", count_o, 32'h0000_1234);
`else
        mtc0(CP0_COMPARE, 32'd10);
        chk("notmr_compare_rd", rdata_o, 32'd0);
        mtc0(CP0_COUNT, 32'h0000_1234);
        chk("notmr_count_rd", rdata_o, 32'd0);
        chk("notmr_count", count_o, 32'd0);
        chk("notmr_ti", {31'd0, timer_int_o}, 32'd0);
`endif

        // Asynchronous reset between clock edges, checked before the next edge.
        #2;
        rst = 1'b0;
        #1;
        chk_reset("async_reset");
        $display("async reset: status=%08h cause=%08h count=%08h", status_o, cause_o, count_o);
        @(negedge clk);
        rst = 1'b1;
        idle(CP0_STATUS);
        chk("post_reset_rdata", rdata_o, 32'h0040_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
